// File: rtl/gcd_pkg.sv
// Shared constants and state encoding for the subtractive GCD engine.
package gcd_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, comparator and subtractors for the GCD engine.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             load,
    input  logic             step,
    output logic             eq,
    output logic             zero,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] z;
    logic             gt;
    logic             lt;

    assign gt   = (x > z);
    assign lt   = (x < z);
    assign eq   = (x == z);
    assign zero = (x == '0) || (z == '0);

    // Only meaningful when eq or zero: equal operands OR to themselves, and a
    // zero operand leaves the other one (or zero when both are zero).
    assign result = x | z;

    // The larger operand is always the minuend, so neither subtraction wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x <= '0;
            z <= '0;
        end else if (load) begin
            x <= A;
            z <= B;
        end else if (step) begin
            if (gt) begin
                x <= x - z;
            end else if (lt) begin
                z <= z - x;
            end
        end
    end

endmodule

// File: rtl/gcd.sv
// Subtractive GCD: FSM controller plus registered result outputs.
module gcd
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             ready
);

    state_t           state;
    state_t           next_state;
    logic             load;
    logic             step;
    logic             finish;
    logic             eq;
    logic             zero;
    logic [WIDTH-1:0] result;

    gcd_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clock (clock),
        .reset (reset),
        .A     (A),
        .B     (B),
        .load  (load),
        .step  (step),
        .eq    (eq),
        .zero  (zero),
        .result(result)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    next_state = CALC;
            CALC:    next_state = (eq || zero) ? DONE : CALC;
            DONE:    next_state = DONE;
            default: next_state = LOAD;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state)
            LOAD: load = 1'b1;
            CALC: begin
                finish = eq || zero;
                step   = !(eq || zero);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Y     <= '0;
            ready <= 1'b0;
        end else if (finish) begin
            Y     <= result;
            ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gcd.sv
// Directed table-driven bench for gcd, with reset-abort sequences.
module tb_gcd;

    localparam int unsigned W      = 8;
    localparam int unsigned BUDGET = 300;

    logic         clock;
    logic         reset;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Y;
    logic         ready;

    int unsigned checks;
    int unsigned errors;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        int unsigned  edges;
    } vec_t;

    vec_t vecs[9];

    gcd #(
        .WIDTH(W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .A    (A),
        .B    (B),
        .Y    (Y),
        .ready(ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reset with operands applied, release at a falling edge, then count rising
    // edges until ready. Inputs are scrambled after the LOAD edge.
    task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_y, input int unsigned exp_edges,
                           input string name);
        int unsigned n;
        reset = 1'b0;
        A = a;
        B = b;
        @(negedge clock);
        @(negedge clock);
        check({name, " reset ready"}, {31'd0, ready}, 32'd0);
        check({name, " reset Y"}, {24'd0, Y}, 32'd0);
        reset = 1'b1;
        n = 0;
        while (n < BUDGET) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 1) begin
                A = ~a;
                B = a ^ b ^ 8'h5a;
            end
            if (ready) break;
        end
        check({name, " edges to ready"}, n, exp_edges);
        check({name, " Y"}, {24'd0, Y}, {24'd0, exp_y});
        repeat (3) @(posedge clock);
        #1;
        check({name, " ready hold"}, {31'd0, ready}, 32'd1);
        check({name, " Y hold"}, {24'd0, Y}, {24'd0, exp_y});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        A      = '0;
        B      = '0;

        vecs[0] = '{a: 8'd6,   b: 8'd2,  y: 8'd2,  edges: 4};
        vecs[1] = '{a: 8'd12,  b: 8'd12, y: 8'd12, edges: 2};
        vecs[2] = '{a: 8'd9,   b: 8'd5,  y: 8'd1,  edges: 7};
        vecs[3] = '{a: 8'd0,   b: 8'd7,  y: 8'd7,  edges: 2};
        vecs[4] = '{a: 8'd0,   b: 8'd0,  y: 8'd0,  edges: 2};
        vecs[5] = '{a: 8'd7,   b: 8'd0,  y: 8'd7,  edges: 2};
        vecs[6] = '{a: 8'd8,   b: 8'd12, y: 8'd4,  edges: 4};
        vecs[7] = '{a: 8'd21,  b: 8'd6,  y: 8'd3,  edges: 6};
        vecs[8] = '{a: 8'd255, b: 8'd1,  y: 8'd1,  edges: 256};

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].edges,
                    $sformatf("vec%0d(%0d,%0d)", i, vecs[i].a, vecs[i].b));
        end

        // Abort a 9,5 computation mid-CALC between clock edges.
        reset = 1'b0;
        A = 8'd9;
        B = 8'd5;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("abort calc ready", {31'd0, ready}, 32'd0);
        check("abort calc Y", {24'd0, Y}, 32'd0);
        run_vec(8'd6, 8'd2, 8'd2, 4, "after abort(6,2)");

        // From DONE, reset must clear ready and Y without waiting for a clock.
        #2;
        reset = 1'b0;
        #1;
        check("abort done ready", {31'd0, ready}, 32'd0);
        check("abort done Y", {24'd0, Y}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
